// File: rtl/bus_ram_loader_if.sv
// bus_ram_loader_if: CPU bus, loader byte port and watchpoint signals of bus_ram_loader.
// dout is the CPU write data; the name do is reserved in SystemVerilog.
interface bus_ram_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] ab;
    logic [DATA_W-1:0] dout;
    logic              we;
    logic [DATA_W-1:0] di;
    logic              cpu_reset;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              wp_en;
    logic [ADDR_W-1:0] wp_addr;
    logic              wp_hit;
    logic [DATA_W-1:0] wp_data;
    logic [7:0]        wp_count;

    modport slave (
        input  ab, dout, we, ld_valid, ld_data, ld_last, wp_en, wp_addr,
        output di, cpu_reset, ld_ready, ld_count, wp_hit, wp_data, wp_count
    );

    modport master (
        output ab, dout, we, ld_valid, ld_data, ld_last, wp_en, wp_addr,
        input  di, cpu_reset, ld_ready, ld_count, wp_hit, wp_data, wp_count
    );
endinterface

// File: rtl/bus_ram_loader.sv
// bus_ram_loader: 6502 system RAM with program loader, CPU reset hold and write watchpoint.
// Define BUS_RAM_CLEAR_EN to fill memory with INIT_FILL before loading.
module bus_ram_loader #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int INIT_FILL   = 0,
    parameter int LOAD_BASE   = 0,
    parameter int RELEASE_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    bus_ram_loader_if.slave  bus
);
    typedef enum logic [1:0] {CLEAR, LOAD, RELEASE, RUN} state_t;

    state_t            state_q, state_d;
    logic [3:0]        rel_q, rel_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wp_hit_q, wp_hit_d;
    logic [DATA_W-1:0] wp_data_q, wp_data_d;
    logic [7:0]        wp_count_q, wp_count_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] clr_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_done, ld_xfer, wp_match, wr_en;

`ifdef BUS_RAM_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    assign clr_addr_d = clr_addr_q + ADDR_W'(state_q == CLEAR);
    always_ff @(posedge clk) begin
        clr_addr_q <= reset ? '0 : clr_addr_d;
    end
    assign clr_addr = clr_addr_q;
    assign clr_done = &clr_addr_q;
`else
    localparam state_t RST_STATE = LOAD;
    assign clr_addr = '0;
    assign clr_done = 1'b0;
`endif

    assign ld_xfer  = state_q == LOAD && bus.ld_valid;
    assign wp_match = state_q == RUN && bus.wp_en && bus.we && bus.ab == bus.wp_addr;

    always_comb begin
        state_d    = state_q;
        rel_d      = rel_q;
        ld_count_d = ld_count_q;
        if (state_q == CLEAR && clr_done)
            state_d = LOAD;
        if (ld_xfer) begin
            ld_count_d = &ld_count_q ? ld_count_q : ld_count_q + 1'b1;
            if (bus.ld_last) begin
                state_d = RELEASE;
                rel_d   = 4'(RELEASE_CYC - 1);
            end
        end
        // loaded with one less so cpu_reset falls exactly RELEASE_CYC edges after ld_last
        if (state_q == RELEASE) begin
            rel_d   = rel_q - 1'b1;
            state_d = rel_q == 4'd0 ? RUN : RELEASE;
        end
        wp_hit_d   = wp_match;
        wp_data_d  = wp_match ? bus.dout : wp_data_q;
        wp_count_d = wp_match && !(&wp_count_q) ? wp_count_q + 8'd1 : wp_count_q;
        wr_en      = !reset && (state_q == CLEAR || ld_xfer || (state_q == RUN && bus.we));
        wr_addr    = state_q == CLEAR ? clr_addr :
                     state_q == LOAD  ? ADDR_W'(LOAD_BASE) + ld_count_q[ADDR_W-1:0] : bus.ab;
        wr_data    = state_q == CLEAR ? DATA_W'(INIT_FILL) :
                     state_q == LOAD  ? bus.ld_data : bus.dout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RST_STATE;
            rel_q      <= '0;
            ld_count_q <= '0;
            addr_q     <= '0;
            wp_hit_q   <= 1'b0;
            wp_data_q  <= '0;
            wp_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rel_q      <= rel_d;
            ld_count_q <= ld_count_d;
            addr_q     <= bus.ab;
            wp_hit_q   <= wp_hit_d;
            wp_data_q  <= wp_data_d;
            wp_count_q <= wp_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign bus.di        = mem[addr_q];
    assign bus.cpu_reset = state_q != RUN;
    assign bus.ld_ready  = state_q == LOAD;
    assign bus.ld_count  = ld_count_q;
    assign bus.wp_hit    = wp_hit_q;
    assign bus.wp_data   = wp_data_q;
    assign bus.wp_count  = wp_count_q;
endmodule

// File: tb/tb_bus_ram_loader.sv
// tb_bus_ram_loader: scenario tasks with a read/hit scoreboard for bus_ram_loader (ADDR_W=8).
module tb_bus_ram_loader;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int FILL = 8'hEA;
    localparam int BASE = 8'hFF;
    localparam int REL  = 2;
`ifdef BUS_RAM_CLEAR_EN
    localparam int CLR_CYC = 256;
    localparam logic [7:0] OLD30 = 8'hEA;
`else
    localparam int CLR_CYC = 0;
    localparam logic [7:0] OLD30 = 8'h5A;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_ram_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_ram_loader #(
        .ADDR_W(AW), .DATA_W(DW), .INIT_FILL(FILL), .LOAD_BASE(BASE), .RELEASE_CYC(REL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic       hit_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bus.ld_data  = d;
        bus.ld_last  = last;
        bus.ld_valid = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_data  = 8'h77;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.ld_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic issue_read(input logic [7:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        bus.ab = a;
        tick();
    endtask

    task automatic test_reset();
        bus.ab = '0; bus.dout = '0; bus.we = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
        bus.wp_en = 1'b0; bus.wp_addr = '0;
        reset = 1'b1;
        tick();
        tick();
        n_cmp += 6;
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset got %b exp 1", bus.cpu_reset); end
        if (bus.ld_ready !== (CLR_CYC == 0)) begin n_fail++; $display("FAIL rst_ld_ready got %b exp %b", bus.ld_ready, CLR_CYC == 0); end
        if (bus.ld_count !== 9'd0) begin n_fail++; $display("FAIL rst_ld_count got %0d exp 0", bus.ld_count); end
        if (bus.wp_hit !== 1'b0) begin n_fail++; $display("FAIL rst_wp_hit got %b exp 0", bus.wp_hit); end
        if (bus.wp_data !== 8'h00) begin n_fail++; $display("FAIL rst_wp_data got %h exp 00", bus.wp_data); end
        if (bus.wp_count !== 8'd0) begin n_fail++; $display("FAIL rst_wp_count got %0d exp 0", bus.wp_count); end
        reset = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        logic [7:0] e;
        logic [7:0] adr[3] = '{8'h00, 8'h7F, 8'hFF};
        wait_ready(n);
        n_cmp++;
        if (n != CLR_CYC) begin n_fail++; $display("FAIL clear_cycles got %0d exp %0d", n, CLR_CYC); end
`ifdef BUS_RAM_CLEAR_EN
        for (int i = 0; i < 3; i++) begin
            issue_read(adr[i], 8'hEA);
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.di !== e) begin n_fail++; $display("FAIL clear_rd[%h] got %h exp %h", adr[i], bus.di, e); end
        end
`else
        n_cmp++;
        if (adr[0] !== 8'h00 || bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL clear_cpu_reset got %b exp 1", bus.cpu_reset); end
`endif
    endtask

    task automatic test_load();
        logic [7:0] e;
        logic [7:0] adr[3] = '{8'hFF, 8'h00, 8'h01};
        logic [7:0] dat[3] = '{8'h38, 8'hA9, 8'h23};
        for (int i = 0; i < 3; i++) send(dat[i], i == 2);
        n_cmp += 3;
        if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop got %b exp 0", bus.ld_ready); end
        if (bus.ld_count !== 9'd3) begin n_fail++; $display("FAIL load_count got %0d exp 3", bus.ld_count); end
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL load_cpu_reset_n got %b exp 1", bus.cpu_reset); end
        tick();
        n_cmp++;
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL load_cpu_reset_n1 got %b exp 1", bus.cpu_reset); end
        tick();
        n_cmp++;
        if (bus.cpu_reset !== 1'b0) begin n_fail++; $display("FAIL load_cpu_reset_n2 got %b exp 0", bus.cpu_reset); end
        for (int i = 0; i < 3; i++) begin
            issue_read(adr[i], dat[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.di !== e) begin n_fail++; $display("FAIL load_rd[%h] got %h exp %h", adr[i], bus.di, e); end
        end
    endtask

    task automatic test_run();
        logic [7:0] e;
        logic [7:0] adr[3] = '{8'h55, 8'h30, 8'h00};
        logic [7:0] dat[3] = '{8'h43, 8'h5A, 8'hA9};
        bus.we = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.ab = adr[i];
            bus.dout = dat[i];
            tick();
        end
        bus.we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_read(adr[i], dat[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.di !== e) begin n_fail++; $display("FAIL run_rd[%h] got %h exp %h", adr[i], bus.di, e); end
        end
    endtask

    task automatic test_watchpoint();
        logic       e;
        int         hits = 0;
        logic [7:0] adr[5] = '{8'h55, 8'h55, 8'h56, 8'h55, 8'h55};
        logic [7:0] dat[5] = '{8'h01, 8'h02, 8'h09, 8'h03, 8'h00};
        logic       wen[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.wp_en = 1'b1;
        bus.wp_addr = 8'h55;
        for (int i = 0; i < 5; i++) begin
            bus.ab = adr[i];
            bus.dout = dat[i];
            bus.we = wen[i];
            hit_q.push_back(wen[i] && adr[i] == 8'h55);
            tick();
            e = hit_q.pop_front();
            hits += int'(bus.wp_hit === 1'b1);
            n_cmp++;
            if (bus.wp_hit !== e) begin n_fail++; $display("FAIL wp_hit[%0d] got %b exp %b", i, bus.wp_hit, e); end
        end
        bus.we = 1'b0;
        n_cmp += 3;
        if (hits != 3) begin n_fail++; $display("FAIL wp_hit_cycles got %0d exp 3", hits); end
        if (bus.wp_data !== 8'h03) begin n_fail++; $display("FAIL wp_data got %h exp 03", bus.wp_data); end
        if (bus.wp_count !== 8'd3) begin n_fail++; $display("FAIL wp_count got %0d exp 3", bus.wp_count); end
        bus.wp_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] e;
        logic       vld[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] dat[4] = '{8'h11, 8'h77, 8'h77, 8'h22};
        logic [7:0] adr[5] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        logic [7:0] img[5] = '{8'h11, 8'h22, 8'h01, 8'h02, 8'h03};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp += 2;
        if (bus.wp_count !== 8'd0) begin n_fail++; $display("FAIL bp_rst_wp_count got %0d exp 0", bus.wp_count); end
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL bp_rst_cpu_reset got %b exp 1", bus.cpu_reset); end
        wait_ready(n);
        n_cmp++;
        if (n != CLR_CYC) begin n_fail++; $display("FAIL bp_clear_cycles got %0d exp %0d", n, CLR_CYC); end
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = vld[i];
            bus.ld_data = dat[i];
            tick();
        end
        bus.ld_valid = 1'b0;
        n_cmp++;
        if (bus.ld_count !== 9'd2) begin n_fail++; $display("FAIL bp_count got %0d exp 2", bus.ld_count); end
        for (int i = 2; i < 5; i++) send(img[i], 1'b0);
        n_cmp += 2;
        if (bus.ld_count !== 9'd5) begin n_fail++; $display("FAIL bp_count5 got %0d exp 5", bus.ld_count); end
        if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL bp_still_loading got %b exp 1", bus.ld_ready); end
        for (int i = 0; i < 5; i++) begin
            issue_read(adr[i], img[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.di !== e) begin n_fail++; $display("FAIL bp_rd[%h] got %h exp %h", adr[i], bus.di, e); end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [7:0] e;
        bus.ab = 8'h30;
        bus.dout = 8'h99;
        bus.we = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp += 2;
        if (bus.ld_count !== 9'd0) begin n_fail++; $display("FAIL mid_ld_count got %0d exp 0", bus.ld_count); end
        if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_reset got %b exp 1", bus.cpu_reset); end
        wait_ready(n);
        n_cmp++;
        if (n != CLR_CYC) begin n_fail++; $display("FAIL mid_clear_cycles got %0d exp %0d", n, CLR_CYC); end
        tick();
        tick();
        bus.we = 1'b0;
        send(8'h44, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (bus.cpu_reset !== 1'b0) begin n_fail++; $display("FAIL mid_release got %b exp 0", bus.cpu_reset); end
        issue_read(8'h30, OLD30);
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.di !== e) begin n_fail++; $display("FAIL mid_rd[30] got %h exp %h", bus.di, e); end
        issue_read(8'hFF, 8'h44);
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.di !== e) begin n_fail++; $display("FAIL mid_rd[ff] got %h exp %h", bus.di, e); end
`ifdef BUS_RAM_CLEAR_EN
        issue_read(8'h03, 8'hEA);
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.di !== e) begin n_fail++; $display("FAIL mid_rd[03] got %h exp %h", bus.di, e); end
`endif
    endtask

    initial begin
        test_reset();
        test_clear();
        test_load();
        test_run();
        test_watchpoint();
        test_backpressure();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
